// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared declarations for the CPU byte-store UART transmit path.
//
// Contents:
//   tx_state_t    - serializer FSM states. PARITY is always declared so the
//                   encoding is identical in every build. Only builds with
//                   UART_TX_PARITY_EN defined ever enter it.
//   UART_TX_ADDR  - store address decoded by the CPU to raise uart_en.
//   clks_per_bit  - clock cycles per serial bit (integer divide).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // The CPU store decode compares against this same constant, so it lives
    // here rather than in either consumer.
    localparam logic [31:0] UART_TX_ADDR = 32'h0002_0020;

    // Any remainder of the divide is dropped. The resulting baud error is
    // the integrator's concern. The result must be at least 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with first-word fall-through: dout always shows the
// oldest entry, so a consumer can take the value in the same cycle it pops.
//
// Parameters:
//   WIDTH - entry width in bits.
//   DEPTH - number of entries. Must be a power of 2 and at least 2.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, empties the FIFO
//   push   in   write din this cycle. Ignored when full, unless pop is also
//               accepted in the same cycle.
//   pop    in   discard the head entry. Ignored when empty.
//   din    in   WIDTH  write data
//   dout   out  WIDTH  head entry. Not meaningful while empty.
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Pointers that differ only in the wrap bit mean full.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push while full is still
    // accepted in that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset. The pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// This block is the UART transmit serializer at the end of the CPU
// byte-store path. Every cycle with uart_en high writes uart_tx_data into a
// FIFO. Bytes leave the FIFO one at a time and go out on tx as 8N1 serial,
// LSB first. The write port has no backpressure. A byte written while the
// FIFO is full, with no pop in that cycle, is dropped and sets the sticky
// overflow flag.
//
// Configuration macro:
//   UART_TX_PARITY_EN - if defined, an even-parity bit follows the data bits
//                       and the framing becomes 8E1 (11 bit times).
//                       If undefined, the framing is 8N1 (10 bit times).
//
// Parameters:
//   CLK_FREQ   - clk frequency in Hz
//   BAUD       - line rate. CLK_FREQ/BAUD must be at least 2.
//   FIFO_DEPTH - buffered bytes. Must be a power of 2 and at least 2.
//
// Ports:
//   clk           in   rising-edge system clock
//   rst_n         in   asynchronous active-low reset. It aborts any frame in
//                      progress and discards the buffered bytes.
//   uart_en       in   write strobe, one byte per asserted cycle
//   uart_tx_data  in   8  byte to send, sampled when uart_en is high
//   tx            out  serial line, registered, idles high
//   busy          out  a frame is in progress or bytes are waiting
//   fifo_full     out  FIFO holds FIFO_DEPTH bytes
//   overflow      out  sticky: a write was dropped. Cleared only by reset.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_en,
    input  logic [7:0] uart_tx_data,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int          CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             tx_reg;

    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;
    logic [7:0]       fifo_dout;
    logic             bit_done;

`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_done = (baud_cnt == BAUD_LAST);

    // A byte is loaded either from IDLE or on the last cycle of a stop bit.
    // The second case lets queued bytes follow each other with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_done));

    // A push that coincides with the FSM's pop is accepted even when full.
    assign fifo_push = uart_en && (!fifo_full || fifo_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (int'(FIFO_DEPTH))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (uart_tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The overflow flag records that at least one byte was dropped.
    // Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (uart_en && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // The parity bit is captured when the byte is loaded. By the time the
    // parity bit is sent, the shift register no longer holds the whole byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if (fifo_pop) begin
            parity_bit <= ^fifo_dout;
        end
    end
`endif

    // Serializer FSM. tx_reg is updated at the same edge as each state
    // change, so the line changes one edge after the decision and tx has no
    // combinational path from the inputs. baud_cnt counts 0..CPB-1 within
    // each bit time. bit_cnt counts the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_reg   <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg <= fifo_dout;
                        state     <= START;
                        tx_reg    <= 1'b0;
                    end
                end

                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx_reg   <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx_reg  <= parity_bit;
`else
                            state   <= STOP;
                            tx_reg  <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_reg  <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx_reg   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            shift_reg <= fifo_dout;
                            state     <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            tx_reg <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                    tx_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: CLK_FREQ=8000, BAUD=1000 (8 clk/bit), FIFO_DEPTH=4.
// A queue-and-frame model predicts tx/busy/fifo_full/overflow every cycle;
// directed sections pin frame shapes and timings with literal values.
module tb_uart_tx;

    localparam int unsigned CLK_FREQ = 8000;
    localparam int unsigned BAUD     = 1000;
    localparam int unsigned DEPTH    = 4;
    localparam int          CPB      = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_en = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state: bytes waiting, and the frame on the line as a bit vector
    // indexed by bit time, plus the cycle offset into that frame.
    logic [7:0]  mq[$];
    logic        m_active;
    int          m_cyc;
    logic [10:0] m_bits;
    logic        m_ovf;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_en      (uart_en),
        .uart_tx_data (uart_tx_data),
        .tx           (tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit k of the result is the line level during bit time k of the frame.
    function automatic logic [10:0] frameOf(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_active = 1'b0;
        m_cyc    = 0;
        m_bits   = '1;
        m_ovf    = 1'b0;
    endtask

    // Advance the model by one clock edge with the inputs sampled there.
    task automatic modelStep(input logic en, input logic [7:0] d);
        logic pop;
        pop = (mq.size() > 0) && (!m_active || m_cyc == FRAME_CYC - 1);
        if (m_active && m_cyc == FRAME_CYC - 1) m_active = 1'b0;
        else if (m_active) m_cyc++;
        if (pop) begin
            m_bits   = frameOf(mq.pop_front());
            m_active = 1'b1;
            m_cyc    = 0;
        end
        if (en) begin
            if (mq.size() < int'(DEPTH)) mq.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Compare process: outputs are checked mid-cycle against the model state,
    // and the model then consumes the inputs that the next edge samples.
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (!rst_n) modelReset();
            checkOutput("tx", 32'(tx), 32'(m_active ? m_bits[m_cyc / CPB] : 1'b1));
            checkOutput("busy", 32'(busy), 32'(m_active || mq.size() > 0));
            checkOutput("fifo_full", 32'(fifo_full), 32'(mq.size() == int'(DEPTH)));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            if (rst_n) modelStep(uart_en, uart_tx_data);
        end
    end

    // One cycle of input: values change 1 time unit after a rising edge and
    // are sampled at the following edge.
    task automatic applyStimulus(input logic en, input logic [7:0] d);
        @(posedge clk);
        #1;
        uart_en      = en;
        uart_tx_data = d;
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        uart_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitFall(output int fall_edge);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx === 1'b1 && n < 100);
        if (tx !== 1'b0) checkOutput("tx_fall_timeout", 32'(tx), 32'd0);
        fall_edge = cyc;
    endtask

    task automatic waitIdle(output int idle_edge);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) checkOutput("idle_timeout", 32'(busy), 32'd0);
        idle_edge = cyc;
    endtask

    task automatic waitUntilCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at the negedge just after tx fell. Each bit is sampled mid-bit,
    // and the busy length is counted from the start edge.
    task automatic watchFrames(input string name, input logic [31:0] exp_bits,
                               input int nbits, input int exp_len);
        int j;
        j = 0;
        while (busy === 1'b1 && j < 2000) begin
            if ((j % CPB) == CPB / 2 && (j / CPB) < nbits)
                checkOutput(name, 32'(tx), 32'(exp_bits[j / CPB]));
            @(negedge clk);
            j++;
        end
        checkOutput({name, "_busy_len"}, j, exp_len);
    endtask

    initial begin
        int s;
        int f;
        int idle;
        int lows;
        int rate;
        logic [7:0] rst_bytes [2];
`ifdef UART_TX_PARITY_EN
        logic [31:0] fr55  = 32'(11'b1_0_01010101_0);
        logic [31:0] frab  = 32'(22'b1_0_00001111_0_1_0_10100011_0);
        logic [31:0] fr07  = 32'(11'b1_1_00000111_0);
        logic [31:0] fr03  = 32'(11'b1_0_00000011_0);
`else
        logic [31:0] fr55  = 32'(10'b1_01010101_0);
        logic [31:0] frab  = 32'(20'b1_00001111_0_1_10100011_0);
`endif
        rst_bytes[0] = 8'hFF;
        rst_bytes[1] = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_full", 32'(fifo_full), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 8'h00);

        // Single byte 0x55: latency one edge, then the full frame.
        applyStimulus(1'b1, 8'h55);
        s = cyc + 1;
        applyStimulus(1'b0, 8'h00);
        waitFall(f);
        checkOutput("latency_55", f - s, 1);
        watchFrames("frame_55", fr55, FRAME_BITS, FRAME_CYC);

        // 0xA3 then 0x0F back to back, with no idle gap between frames.
        repeat (5) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'hA3);
        s = cyc + 1;
        applyStimulus(1'b1, 8'h0F);
        applyStimulus(1'b0, 8'h00);
        waitFall(f);
        checkOutput("latency_a3", f - s, 1);
        watchFrames("frames_a3_0f", frab, 2 * FRAME_BITS, 2 * FRAME_CYC);

        // Six writes into the depth-4 FIFO. 0x01 is popped at once, 0x02..0x05
        // fill the FIFO, and 0x06 is dropped.
        repeat (5) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h01);
        s = cyc + 1;
        for (int d = 2; d <= 6; d++) applyStimulus(1'b1, 8'(d));
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        checkOutput("ovf_full_seen", 32'(fifo_full), 32'd1);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        waitIdle(idle);
        checkOutput("ovf_busy_len", idle - s, 1 + 5 * FRAME_CYC);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        // Push while full, in the same cycle the FSM pops at the end of a frame.
        resetPulse();
        applyStimulus(1'b1, 8'h11);
        s = cyc + 1;
        for (int d = 8'h12; d <= 8'h15; d++) applyStimulus(1'b1, 8'(d));
        applyStimulus(1'b0, 8'h00);
        f = s + 1;
        waitUntilCycle(f + FRAME_CYC - 2);
        checkOutput("pp_full_before", 32'(fifo_full), 32'd1);
        applyStimulus(1'b1, 8'h16);
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        checkOutput("pp_no_overflow", 32'(overflow), 32'd0);
        checkOutput("pp_still_full", 32'(fifo_full), 32'd1);
        waitIdle(idle);
        checkOutput("pp_busy_len", idle - f, 6 * FRAME_CYC);
        checkOutput("pp_overflow_end", 32'(overflow), 32'd0);

        // Reset in the middle of the data bits, with a second byte queued.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, rst_bytes[k]);
            s = cyc + 1;
            applyStimulus(1'b1, 8'hC3);
            applyStimulus(1'b0, 8'h00);
            waitUntilCycle(s + 1 + 3 * CPB + 2);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            checkOutput("midreset_tx", 32'(tx), 32'd1);
            checkOutput("midreset_busy", 32'(busy), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            lows = 0;
            repeat (150) begin
                @(negedge clk);
                if (tx !== 1'b1 || busy !== 1'b0) lows++;
            end
            checkOutput("no_residual", lows, 0);
        end

`ifdef UART_TX_PARITY_EN
        applyStimulus(1'b1, 8'h07);
        applyStimulus(1'b0, 8'h00);
        waitFall(f);
        watchFrames("frame_07", fr07, FRAME_BITS, 88);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b0, 8'h00);
        waitFall(f);
        watchFrames("frame_03", fr03, FRAME_BITS, 88);
`endif

        // Random traffic: alternating sparse and dense phases, with one reset
        // while traffic is running.
        for (int p = 0; p < 8; p++) begin
            rate = (p % 2 == 1) ? 70 : 4;
            if (p == 4) resetPulse();
            for (int c = 0; c < 400; c++)
                applyStimulus($urandom_range(0, 99) < rate, 8'($urandom));
        end
        applyStimulus(1'b0, 8'h00);
        waitIdle(idle);
        @(negedge clk);
        checkOutput("drain_tx_idle", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
